// File: rtl/lsu_bus_if.sv
// Memory-stage load/store unit: issues one valid/ready bus access per M-stage instruction and returns extended load data.
// Latency: a zero-wait store stalls for 1 cycle, a zero-wait load for 2. Data and pipeline release come in DONE.
// Backpressure: bus_req is held with stable fields until bus_gnt. StallLSU holds IF..M until the access is done or times out.
module lsu_bus_if #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  MemReadWriteM,
    input  logic [1:0]  data_typeM,
    input  logic        unsignM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    input  logic        HoldM,
    output logic        StallLSU,
    output logic [31:0] ReadDataM,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic        cap_we;
    logic [1:0]  cap_type;
    logic        cap_unsign;
    logic [1:0]  cap_off;

    logic        align_ok;
    logic        rw_ok;
    logic        idle_act;
    logic        issue;
    logic [3:0]  new_be;
    logic [31:0] new_wdata;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    always_comb begin
        align_ok = 1'b0;
        case (data_typeM)
            2'b00:   align_ok = (AddrM[1:0] == 2'b00);
            2'b01:   align_ok = ~AddrM[0];
            2'b10:   align_ok = 1'b1;
            default: align_ok = 1'b0;
        endcase
    end

    assign rw_ok    = (MemReadWriteM == 2'b10) || (MemReadWriteM == 2'b01);
    assign idle_act = (state == S_IDLE) && !reset;
    assign issue    = idle_act && rw_ok && align_ok;
    // Bad accesses never reach the bus and never stall; the trap logic consumes the pulse.
    assign misalign = idle_act && (MemReadWriteM != 2'b00) && !(rw_ok && align_ok);

    always_comb begin
        new_be    = 4'b1111;
        new_wdata = WriteDataM;
        case (data_typeM)
            2'b10: begin
                new_be    = 4'b0001 << AddrM[1:0];
                new_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                new_be    = 4'b0011 << {AddrM[1], 1'b0};
                new_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                new_be    = 4'b1111;
                new_wdata = WriteDataM;
            end
        endcase
    end

    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        if (issue) begin
            bus_req   = 1'b1;
            bus_we    = MemReadWriteM[0];
            bus_addr  = {AddrM[31:2], 2'b00};
            bus_be    = new_be;
            bus_wdata = new_wdata;
        end else if (state == S_REQ) begin
            bus_req   = 1'b1;
            bus_we    = cap_we;
            bus_addr  = cap_addr;
            bus_be    = cap_be;
            bus_wdata = cap_wdata;
        end
    end

    assign StallLSU = issue || (state == S_REQ) || (state == S_WAIT);

    always_comb begin
        lane_b   = bus_rdata[{cap_off, 3'b000} +: 8];
        lane_h   = cap_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_ext = bus_rdata;
        case (cap_type)
            2'b10:   load_ext = cap_unsign ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_ext = cap_unsign ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cap_addr   <= '0;
            cap_be     <= '0;
            cap_wdata  <= '0;
            cap_we     <= 1'b0;
            cap_type   <= '0;
            cap_unsign <= 1'b0;
            cap_off    <= '0;
            bus_err    <= 1'b0;
            ReadDataM  <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        cap_addr   <= {AddrM[31:2], 2'b00};
                        cap_be     <= new_be;
                        cap_wdata  <= new_wdata;
                        cap_we     <= MemReadWriteM[0];
                        cap_type   <= data_typeM;
                        cap_unsign <= unsignM;
                        cap_off    <= AddrM[1:0];
                        cnt        <= '0;
                        if (bus_gnt) state <= MemReadWriteM[0] ? S_DONE : S_WAIT;
                        else         state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A grant in the last counted cycle still wins over the abort.
                    if (bus_gnt) begin
                        cnt   <= '0;
                        state <= cap_we ? S_DONE : S_WAIT;
                    end else if (cnt == CNT_LAST) begin
                        bus_err   <= 1'b1;
                        ReadDataM <= '0;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (bus_rvalid) begin
                        ReadDataM <= load_ext;
                        state     <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        bus_err   <= 1'b1;
                        ReadDataM <= '0;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (!HoldM) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
